// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding command/response to AXI4-Lite initiator.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ_AR,
        WAIT_R,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic aw_left;
    logic w_left;
    logic b_got_q;
    logic tmo;

    assign accept  = cmd_valid && cmd_ready;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign b_hs    = BVALID && BREADY;
    assign ar_hs   = ARVALID && ARREADY;
    assign r_hs    = RVALID && RREADY;
    assign aw_left = AWVALID && !AWREADY;
    assign w_left  = WVALID && !WREADY;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             busy;
    logic [CNT_W-1:0] tmo_cnt;

    assign busy = (state_q == WRITE) || (state_q == WAIT_B) ||
                  (state_q == READ_AR) || (state_q == WAIT_R);

    // Watchdog: restart on each accepted command, count while busy
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (busy) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo = busy &&
                 (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    // Next-state: one transaction at a time, B may beat AW/W
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = cmd_write ? WRITE : READ_AR;
                end
            end
            WRITE: begin
                if (!aw_left && !w_left) begin
                    state_d = (b_got_q || b_hs) ? RESP : WAIT_B;
                end
            end
            WAIT_B: begin
                if (b_hs) begin
                    state_d = RESP;
                end
            end
            READ_AR: begin
                if (ar_hs) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                if (r_hs) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo) begin
            state_d = RESP;
        end
    end

    // State register and registered command-side flags
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == RESP);
        end
    end

    // AXI channel outputs: raise on accept, drop on own handshake
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            AWADDR  <= '0;
            WDATA   <= '0;
            WSTRB   <= '0;
            ARADDR  <= '0;
            AWVALID <= 1'b0;
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            ARVALID <= 1'b0;
            RREADY  <= 1'b0;
        end else begin
            if (accept && cmd_write) begin
                AWADDR  <= cmd_addr;
                WDATA   <= cmd_wdata;
                WSTRB   <= cmd_wstrb;
                AWVALID <= 1'b1;
                WVALID  <= 1'b1;
                BREADY  <= 1'b1;
            end
            if (accept && !cmd_write) begin
                ARADDR  <= cmd_addr;
                ARVALID <= 1'b1;
            end
            if (aw_hs) begin
                AWVALID <= 1'b0;
            end
            if (w_hs) begin
                WVALID <= 1'b0;
            end
            if (b_hs) begin
                BREADY <= 1'b0;
            end
            if (ar_hs) begin
                ARVALID <= 1'b0;
                RREADY  <= 1'b1;
            end
            if (r_hs) begin
                RREADY <= 1'b0;
            end
            if (tmo) begin
                AWVALID <= 1'b0;
                WVALID  <= 1'b0;
                BREADY  <= 1'b0;
                ARVALID <= 1'b0;
                RREADY  <= 1'b0;
            end
        end
    end

    // Response capture from B/R, or synthetic error on watchdog
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            b_got_q     <= 1'b0;
        end else begin
            if (accept) begin
                rsp_timeout <= 1'b0;
                b_got_q     <= 1'b0;
            end
            if (b_hs) begin
                b_got_q   <= 1'b1;
                rsp_resp  <= BRESP;
                rsp_rdata <= '0;
            end
            if (r_hs) begin
                rsp_resp  <= RRESP;
                rsp_rdata <= RDATA;
            end
            if (tmo) begin
                rsp_resp    <= 2'b11;
                rsp_rdata   <= '0;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: random command stream against a register-slave model.
// Define AXI_MASTER_TIMEOUT_EN to also exercise the watchdog.
module tb_axi4_lite_master;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic        ARESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    axi4_lite_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID),
        .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model: per-channel READY delay, registered B/R
    int   aw_dly = 0;
    int   w_dly  = 0;
    int   ar_dly = 0;
    logic ar_block = 1'b0;
    logic r_stall  = 1'b0;
    int   awc, wc, arc;
    logic [31:0] mem [16];
    logic        mem_ok = 1'b0;
    logic        got_aw, got_w, r_pend;
    logic [31:0] sa, sd, ra;
    logic [3:0]  ss;
    logic [31:0] e_addr, e_data, merged, r_addr, r_word;
    logic [3:0]  e_strb;
    logic        r_err;

    always_comb begin
        AWREADY = (awc >= aw_dly);
        WREADY  = (wc >= w_dly);
        ARREADY = !ar_block && (arc >= ar_dly);
        e_addr  = (AWVALID && AWREADY) ? AWADDR : sa;
        e_data  = (WVALID && WREADY) ? WDATA : sd;
        e_strb  = (WVALID && WREADY) ? WSTRB : ss;
        merged  = mem[e_addr[5:2]];
        for (int b = 0; b < 4; b++) begin
            if (e_strb[b]) merged[8*b +: 8] = e_data[8*b +: 8];
        end
        r_addr = r_pend ? ra : ARADDR;
        r_err  = (r_addr >= 32'h40);
        r_word = r_err ? 32'h0 : mem[r_addr[5:2]];
    end

    always @(posedge ACLK) begin
        if (ARESET) begin
            awc <= 0; wc <= 0; arc <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
            BVALID <= 1'b0; RVALID <= 1'b0;
            BRESP <= 2'b00; RRESP <= 2'b00; RDATA <= 32'h0;
            sa <= 32'h0; sd <= 32'h0; ss <= 4'h0; ra <= 32'h0;
            if (!mem_ok) begin
                for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
                mem[1] <= 32'hDEADBEEF;
                mem_ok <= 1'b1;
            end
        end else begin
            awc <= (AWVALID && !AWREADY) ? awc + 1 : 0;
            wc  <= (WVALID && !WREADY) ? wc + 1 : 0;
            arc <= (ARVALID && !ARREADY) ? arc + 1 : 0;
            if (AWVALID && AWREADY) begin
                got_aw <= 1'b1; sa <= AWADDR;
            end
            if (WVALID && WREADY) begin
                got_w <= 1'b1; sd <= WDATA; ss <= WSTRB;
            end
            if (BVALID && BREADY) BVALID <= 1'b0;
            if ((got_aw || (AWVALID && AWREADY)) &&
                (got_w || (WVALID && WREADY))) begin
                got_aw <= 1'b0;
                got_w  <= 1'b0;
                BVALID <= 1'b1;
                if (e_addr < 32'h40) begin
                    mem[e_addr[5:2]] <= merged;
                    BRESP <= 2'b00;
                end else begin
                    BRESP <= 2'b10;
                end
            end
            if (RVALID && RREADY) RVALID <= 1'b0;
            if ((ARVALID && ARREADY) || r_pend) begin
                if (r_stall) begin
                    r_pend <= 1'b1;
                    ra     <= r_addr;
                end else begin
                    r_pend <= 1'b0;
                    RVALID <= 1'b1;
                    RDATA  <= r_word;
                    RRESP  <= r_err ? 2'b10 : 2'b00;
                end
            end
        end
    end

    // Bus monitor: VALID-hold rule, B count, activity counters
    int   hold_err  = 0;
    int   b_cnt     = 0;
    int   act_cnt   = 0;
    int   wonly_cnt = 0;
    logic p_rst = 1'b1;
    logic p_awp = 1'b0;
    logic p_wp  = 1'b0;
    logic p_arp = 1'b0;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    always @(negedge ACLK) begin
        if (!p_rst && !rsp_timeout) begin
            if (p_awp && (AWVALID !== 1'b1 || AWADDR !== p_awaddr)) begin
                hold_err++;
                $display("aw hold broken at %0t", $time);
            end
            if (p_wp && (WVALID !== 1'b1 || WDATA !== p_wdata ||
                         WSTRB !== p_wstrb)) begin
                hold_err++;
                $display("w hold broken at %0t", $time);
            end
            if (p_arp && (ARVALID !== 1'b1 || ARADDR !== p_araddr)) begin
                hold_err++;
                $display("ar hold broken at %0t", $time);
            end
        end
        if (BVALID && BREADY) b_cnt++;
        if (AWVALID || WVALID || ARVALID) act_cnt++;
        if (WVALID && !AWVALID) wonly_cnt++;
        p_rst    <= ARESET;
        p_awp    <= AWVALID && !AWREADY;
        p_wp     <= WVALID && !WREADY;
        p_arp    <= ARVALID && !ARREADY;
        p_awaddr <= AWADDR;
        p_wdata  <= WDATA;
        p_wstrb  <= WSTRB;
        p_araddr <= ARADDR;
    end

    // Reference register file
    logic [31:0] ref_mem [16];

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r);
        if (a >= 64) begin
            r = 2'b10;
        end else begin
            r = 2'b00;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) ref_mem[a / 4][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic ref_read(input logic [31:0] a,
                            output logic [31:0] d, output logic [1:0] r);
        if (a >= 64) begin
            d = 32'h0; r = 2'b10;
        end else begin
            d = ref_mem[a / 4]; r = 2'b00;
        end
    endtask

    task automatic step;
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_dly(input int a, input int w, input int r);
        aw_dly = a; w_dly = w; ar_dly = r;
    endtask

    // Drive one command; report latency (cycles) and the response
    task automatic run_cmd(input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [31:0] rd,
                           output logic [1:0] rr, output logic to,
                           output int bn, output logic chv);
        int g;
        int b0;
        g = 0;
        while (!cmd_ready && g < 50) begin
            step; g++;
        end
        cmd_valid = 1'b1; cmd_write = wr;
        cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        b0 = b_cnt;
        step;
        cmd_valid = 1'b0;
        chv = wr ? (AWVALID && WVALID && !ARVALID)
                 : (ARVALID && !AWVALID && !WVALID);
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            step; lat++;
        end
        rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
        bn = b_cnt - b0;
        step;
    endtask

    task automatic test_reset;
        ARESET = 1'b1;
        repeat (3) step;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_timeout, AWVALID, WVALID,
             BREADY, ARVALID, RREADY} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b required 00000000",
                     {cmd_ready, rsp_valid, rsp_timeout, AWVALID,
                      WVALID, BREADY, ARVALID, RREADY});
        end
        n_checks++;
        if ({rsp_rdata, rsp_resp} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h/%b required 0/00",
                     rsp_rdata, rsp_resp);
        end
        n_checks++;
        if ({AWADDR, ARADDR, WDATA, WSTRB} !== 100'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h %h %h %h required 0",
                     AWADDR, ARADDR, WDATA, WSTRB);
        end
        ARESET = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rel0: cmd_ready %b required 0", cmd_ready);
        end
        step;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rel1: cmd_ready %b required 1", cmd_ready);
        end
    endtask

    task automatic test_basic;
        int lat, bn, h0;
        logic [31:0] rd, ed;
        logic [1:0]  rr, er;
        logic to, chv;
        h0 = hold_err;
        set_dly(0, 0, 0);
        ref_write(32'h0, 32'h12345678, 4'hF, er);
        run_cmd(1'b1, 32'h0, 32'h12345678, 4'hF, lat, rd, rr, to, bn, chv);
        n_checks++;
        if (chv !== 1'b1 || lat != 3 || bn != 1) begin
            n_fail++;
            $display("FAIL basic_wr_timing: chv=%b lat=%0d b=%0d required 1/3/1",
                     chv, lat, bn);
        end
        n_checks++;
        if (rr !== er || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_wr_rsp: got %b/%h required %b/0", rr, rd, er);
        end
        ref_read(32'h0, ed, er);
        run_cmd(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, rr, to, bn, chv);
        n_checks++;
        if (rd !== ed || rr !== er || lat != 3 || chv !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_rd0: got %h/%b lat %0d required %h/%b lat 3",
                     rd, rr, lat, ed, er);
        end
        ref_read(32'h4, ed, er);
        run_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat, rd, rr, to, bn, chv);
        n_checks++;
        if (rd !== ed || rr !== er) begin
            n_fail++;
            $display("FAIL basic_rd4: got %h/%b required %h/%b", rd, rr, ed, er);
        end
        n_checks++;
        if (hold_err != h0) begin
            n_fail++;
            $display("FAIL basic_hold: %0d violations required 0", hold_err - h0);
        end
    endtask

    task automatic test_split_write;
        int lat, bn, w0, h0;
        logic [31:0] rd, ed, d;
        logic [1:0]  rr, er;
        logic to, chv;
        h0 = hold_err;
        d = $urandom;
        set_dly(0, 3, 0);
        ref_write(32'h8, d, 4'b0101, er);
        w0 = wonly_cnt;
        run_cmd(1'b1, 32'h8, d, 4'b0101, lat, rd, rr, to, bn, chv);
        n_checks++;
        if (lat != 6 || bn != 1 || wonly_cnt - w0 != 3 || rr !== er) begin
            n_fail++;
            $display("FAIL split_wr: lat=%0d b=%0d wonly=%0d resp=%b required 6/1/3/%b",
                     lat, bn, wonly_cnt - w0, rr, er);
        end
        n_checks++;
        if (hold_err != h0) begin
            n_fail++;
            $display("FAIL split_hold: %0d violations required 0", hold_err - h0);
        end
        set_dly(0, 0, 0);
        ref_read(32'h8, ed, er);
        run_cmd(1'b0, 32'h8, 32'h0, 4'h0, lat, rd, rr, to, bn, chv);
        n_checks++;
        if (rd !== ed || rr !== er) begin
            n_fail++;
            $display("FAIL split_rdback: got %h/%b required %h/%b", rd, rr, ed, er);
        end
    endtask

    task automatic test_late_ready;
        int lat, bn;
        logic [31:0] rd, ed, d;
        logic [1:0]  rr, er;
        logic to, chv;
        d = $urandom;
        set_dly(1, 1, 1);
        ref_write(32'hC, d, 4'hF, er);
        run_cmd(1'b1, 32'hC, d, 4'hF, lat, rd, rr, to, bn, chv);
        n_checks++;
        if (lat != 4 || bn != 1 || rr !== er) begin
            n_fail++;
            $display("FAIL late_wr: lat=%0d b=%0d resp=%b required 4/1/%b",
                     lat, bn, rr, er);
        end
        ref_read(32'hC, ed, er);
        run_cmd(1'b0, 32'hC, 32'h0, 4'h0, lat, rd, rr, to, bn, chv);
        n_checks++;
        if (lat != 4 || rd !== ed || rr !== er) begin
            n_fail++;
            $display("FAIL late_rd: lat=%0d data=%h required 4/%h", lat, rd, ed);
        end
        set_dly(0, 0, 0);
    endtask

    task automatic test_backpressure;
        int lat, bn, a0;
        logic [31:0] rd, ed;
        logic [1:0]  rr, er;
        logic to, chv;
        rsp_ready = 1'b0;
        ref_read(32'h4, ed, er);
        run_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat, rd, rr, to, bn, chv);
        a0 = act_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== ed ||
                rsp_resp !== er || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: v=%b d=%h r=%b cr=%b required 1/%h/%b/0",
                         i, rsp_valid, rsp_rdata, rsp_resp, cmd_ready, ed, er);
            end
            step;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (act_cnt != a0) begin
            n_fail++;
            $display("FAIL bp_quiet: %0d VALID cycles required 0", act_cnt - a0);
        end
        rsp_ready = 1'b1;
        step;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: v=%b cr=%b required 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bn, g;
        logic [31:0] rd, ed;
        logic [1:0]  rr, er;
        logic to, chv;
        r_stall = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
        step;
        cmd_valid = 1'b0;
        g = 0;
        while (!RREADY && g < 10) begin
            step; g++;
        end
        n_checks++;
        if (RREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_wait_r: RREADY %b required 1", RREADY);
        end
        ARESET = 1'b1;
        step;
        n_checks++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid} !== 6'h0) begin
            n_fail++;
            $display("FAIL rmid_drop: got %b required 000000",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid});
        end
        ARESET = 1'b0;
        r_stall = 1'b0;
        step;
        ref_read(32'h0, ed, er);
        run_cmd(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, rr, to, bn, chv);
        n_checks++;
        if (rd !== ed || rr !== er || lat != 3) begin
            n_fail++;
            $display("FAIL rmid_after: got %h/%b lat %0d required %h/%b lat 3",
                     rd, rr, lat, ed, er);
        end
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int lat, bn, g, arv;
        logic [31:0] rd, ed;
        logic [1:0]  rr, er;
        logic to, chv;
        ar_block = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
        step;
        cmd_valid = 1'b0;
        g = 0; arv = 0;
        while (!rsp_valid && g < 40) begin
            if (ARVALID) arv++;
            step; g++;
        end
        n_checks++;
        if (arv != 8 || ARVALID !== 1'b0 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_len: arvalid cycles %0d ARVALID %b rsp_valid %b required 8/0/1",
                     arv, ARVALID, rsp_valid);
        end
        n_checks++;
        if (rsp_resp !== 2'b11 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL tmo_rsp: %b/%b/%h required 11/1/0",
                     rsp_resp, rsp_timeout, rsp_rdata);
        end
        step;
        ar_block = 1'b0;
        ref_read(32'h0, ed, er);
        run_cmd(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, rr, to, bn, chv);
        n_checks++;
        if (to !== 1'b0 || rd !== ed || rr !== er) begin
            n_fail++;
            $display("FAIL tmo_clear: to=%b d=%h r=%b required 0/%h/%b",
                     to, rd, rr, ed, er);
        end
    endtask
`endif

    task automatic test_random;
        int lat, bn, el, h0;
        logic wr, to, chv;
        logic [31:0] a, d, rd, ed;
        logic [3:0]  s;
        logic [1:0]  rr, er;
        h0 = hold_err;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 19)) * 32'd4;
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            set_dly($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
            if (wr) begin
                ref_write(a, d, s, er);
                ed = 32'h0;
                el = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly);
            end else begin
                ref_read(a, ed, er);
                el = 3 + ar_dly;
            end
            run_cmd(wr, a, d, s, lat, rd, rr, to, bn, chv);
            n_checks++;
            if (rd !== ed || rr !== er || to !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_rsp: wr=%b a=%h got %h/%b/%b required %h/%b/0",
                         i, wr, a, rd, rr, to, ed, er);
            end
            n_checks++;
            if (lat != el || bn != (wr ? 1 : 0) || chv !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd%0d_tim: lat=%0d b=%0d chv=%b required %0d/%0d/1",
                         i, lat, bn, chv, el, wr ? 1 : 0);
            end
        end
        n_checks++;
        if (hold_err != h0) begin
            n_fail++;
            $display("FAIL rnd_hold: %0d violations required 0", hold_err - h0);
        end
        set_dly(0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        ref_mem[1] = 32'hDEADBEEF;
        test_reset;
        test_basic;
        test_split_write;
        test_late_ready;
        test_backpressure;
        test_reset_mid;
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout;
`endif
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

AXI4-Lite initiator that converts a simple single-outstanding command/response interface into AXI4-Lite read and write transactions. It sits between local control logic (sequencers, CPU-less config engines) and the team's AXI4-Lite register slaves, handling one transaction at a time with fully registered channel outputs.

## Interface
- ADDR_W, 32, address width on cmd_addr, AWADDR, ARADDR
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT_CYCLES, 256, watchdog limit; used only with AXI_MASTER_TIMEOUT_EN
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transaction address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP, or 2'b11 on timeout
- rsp_timeout  out  1  response produced by watchdog
- AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out  (standard AXI4-Lite widths)

## Operation
- States: IDLE, WRITE (AW+W), WAIT_B, READ_AR, WAIT_R, RESP.
- IDLE: cmd_ready=1. On cmd_valid: latch addr/wdata/wstrb; write -> WRITE, read -> READ_AR.
- WRITE: AWVALID and WVALID both high, AWADDR/WDATA/WSTRB stable. Each VALID drops independently on its own handshake (VALID && READY). Both must assert together on entry; neither waits for the other. When both have handshaken (same or different cycles) -> WAIT_B.
- BREADY high in WRITE and WAIT_B. On BVALID && BREADY: latch BRESP into rsp_resp, rsp_rdata=0 -> RESP.
- READ_AR: ARVALID high until ARVALID && ARREADY -> WAIT_R.
- WAIT_R: RREADY high; on RVALID && RREADY latch RDATA/RRESP -> RESP.
- RESP: rsp_valid=1, rsp data stable; on rsp_ready -> IDLE.
- Never more than one transaction outstanding; AW/W addresses are never reordered.
- No VALID deasserts before its handshake (AXI rule), except via timeout.
- Reset mid-transaction: all VALIDs/READYs drop next edge, state -> IDLE; in-flight response is discarded.

## Timing
- Reset values: cmd_ready 0 during reset (1 the cycle after reset release), rsp_valid 0, rsp_rdata 0, rsp_resp 0, rsp_timeout 0, AWVALID/WVALID/ARVALID 0, BREADY/RREADY 0, AWADDR/ARADDR/WDATA/WSTRB 0.
- All outputs registered. Command accepted at edge N -> channel VALIDs high from cycle N+1.
- Response handshake at edge M -> rsp_valid high from cycle M+1.
- Zero-wait slave (READY already high): write cmd-to-rsp_valid = 3 cycles, read = 3 cycles.
- Slave with one-cycle-late READY and registered B/R (team slave style): write 4 cycles, read 4 cycles.
- BVALID arriving while AW/W still pending is accepted (BREADY already high).
- cmd_ready is 0 in RESP; back-to-back commands separated by at least one IDLE cycle.

## Configuration
- AXI_MASTER_TIMEOUT_EN defined: a counter clears on entry to WRITE/READ_AR and increments each cycle in WRITE, WAIT_B, READ_AR, WAIT_R. On reaching TIMEOUT_CYCLES: all VALIDs/READYs drop, rsp_resp=2'b11, rsp_rdata=0, rsp_timeout=1 -> RESP. rsp_timeout clears on next accepted command. Debug-only; deliberately breaks the VALID-hold rule.
- Undefined: no counter, rsp_timeout tied 0, master waits indefinitely.

## Test plan
- Write addr 0x00 data 0x12345678 strb 0xF to register slave -> AWVALID/WVALID high same cycle, single BREADY handshake, rsp_resp=00, rsp_rdata=0.
- Read addr 0x00 after that write -> rsp_rdata=0x12345678, rsp_resp=00; read addr 0x04 -> rsp_rdata=0xDEADBEEF.
- Slave asserting WREADY 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held with stable WDATA until WREADY, exactly one B accepted.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and data stable, cmd_ready 0, no new AXI activity.
- ARESET asserted while in WAIT_R -> next cycle all VALID/READY 0, rsp_valid 0; new read after release completes normally.
- With AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts ARREADY -> after 8 cycles ARVALID 0, rsp_valid 1, rsp_resp=11, rsp_timeout=1.
